// File: rtl/gpio_input_monitor.sv
// gpio_input_monitor: two-flop synchroniser, per-bit debounce, edge pulses,
// sticky change flags and a saturating start-trigger event counter.
module gpio_input_monitor #(
  parameter int WIDTH           = 45,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TRIG_BIT        = 0,
  parameter int CNT_W           = 16
) (
  input  logic             sys_clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] gpio_stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] change_flags_o,
  output logic             start_trigger_o,
  output logic             trig_pulse_o,
  output logic [CNT_W-1:0] trig_cnt_o
);

  // Counter value at which a persistent disagreement is accepted.
  localparam logic [7:0]       CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] flags_q;
  logic [WIDTH-1:0] flags_d;
  logic [CNT_W-1:0] trig_cnt_q;
  logic [CNT_W-1:0] trig_cnt_d;

  // Two-flop synchroniser; nothing else looks at the raw pins.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [7:0] cnt_q;
      logic [7:0] cnt_d;
      logic       stable_q;
      logic       stable_d;
      logic       rise_q;
      logic       rise_d;
      logic       fall_q;
      logic       fall_d;

      // Debounce: count consecutive disagreeing samples, flip on the last one.
      always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync2_q[gi] == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = sync2_q[gi];
          cnt_d    = '0;
          rise_d   = sync2_q[gi];
          fall_d   = ~sync2_q[gi];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // Per-bit debounce state and registered edge pulses.
      always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
          rise_q   <= 1'b0;
          fall_q   <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
          rise_q   <= rise_d;
          fall_q   <= fall_d;
        end
      end

      assign gpio_stable_o[gi] = stable_q;
      assign rise_o[gi]        = rise_q;
      assign fall_o[gi]        = fall_q;
    end
  endgenerate

  // Sticky flags and trigger counter react to the visible pulses; a pulse
  // in the same cycle as clear_i survives the clear.
  always_comb begin
    flags_d    = flags_q;
    trig_cnt_d = trig_cnt_q;
    if (clear_i) begin
      flags_d    = '0;
      trig_cnt_d = '0;
    end
    flags_d = flags_d | rise_o | fall_o;
    if (rise_o[TRIG_BIT]) begin
      if (clear_i) begin
        trig_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (trig_cnt_q != CNT_MAX) begin
        trig_cnt_d = trig_cnt_q + 1'b1;
      end
    end
  end

  // Registers for the flags and the trigger event counter.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      flags_q    <= '0;
      trig_cnt_q <= '0;
    end else begin
      flags_q    <= flags_d;
      trig_cnt_q <= trig_cnt_d;
    end
  end

  assign change_flags_o  = flags_q;
  assign trig_cnt_o      = trig_cnt_q;
  assign start_trigger_o = gpio_stable_o[TRIG_BIT];
  assign trig_pulse_o    = rise_o[TRIG_BIT];

endmodule

// File: tb/tb_gpio_input_monitor.sv
// Directed testbench for gpio_input_monitor (DEBOUNCE_CYCLES=4, CNT_W=4).
module tb_gpio_input_monitor;

  localparam int W  = 45;
  localparam int DC = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  gpio;
  logic          clr;
  logic [W-1:0]  stable;
  logic [W-1:0]  rise;
  logic [W-1:0]  fall;
  logic [W-1:0]  flags;
  logic          start_trig;
  logic          trig_pulse;
  logic [CW-1:0] trig_cnt;

  int tests;
  int fails;

  gpio_input_monitor #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DC), .TRIG_BIT(0), .CNT_W(CW)
  ) dut (
    .sys_clk_i      (clk),
    .rst_i          (rst),
    .gpio_i         (gpio),
    .clear_i        (clr),
    .gpio_stable_o  (stable),
    .rise_o         (rise),
    .fall_o         (fall),
    .change_flags_o (flags),
    .start_trigger_o(start_trig),
    .trig_pulse_o   (trig_pulse),
    .trig_cnt_o     (trig_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; gpio = '0;
    tick(3);
    tests++; if (stable !== '0) begin fails++; $display("FAIL reset_stable got %h want 0", stable); end
    tests++; if ((rise | fall) !== '0) begin fails++; $display("FAIL reset_pulses got %h want 0", rise | fall); end
    tests++; if (flags !== '0) begin fails++; $display("FAIL reset_flags got %h want 0", flags); end
    tests++; if (trig_cnt !== '0) begin fails++; $display("FAIL reset_cnt got %0d want 0", trig_cnt); end
    tests++; if ({start_trig, trig_pulse} !== 2'b00) begin fails++; $display("FAIL reset_trig got %b want 00", {start_trig, trig_pulse}); end
    rst = 1'b0;
    tick(2);
    $display("[TB] test_reset done");
  endtask

  task automatic test_trigger_rise();
    gpio[0] = 1'b1;          // captured into sync1 at the next edge (k)
    tick(5);                 // edge k+4: still not flipped
    tests++; if (stable[0] !== 1'b0) begin fails++; $display("FAIL rise_early got %b want 0", stable[0]); end
    tick(1);                 // edge k+5: flip and pulse
    tests++; if (stable[0] !== 1'b1) begin fails++; $display("FAIL rise_stable got %b want 1", stable[0]); end
    tests++; if (rise !== 45'h1) begin fails++; $display("FAIL rise_pulse got %h want 1", rise); end
    tests++; if (trig_pulse !== 1'b1) begin fails++; $display("FAIL rise_trig_pulse got %b want 1", trig_pulse); end
    tick(1);
    tests++; if (rise !== '0) begin fails++; $display("FAIL rise_one_cycle got %h want 0", rise); end
    tests++; if (trig_cnt !== 4'd1) begin fails++; $display("FAIL rise_cnt got %0d want 1", trig_cnt); end
    tests++; if (flags !== 45'h1) begin fails++; $display("FAIL rise_flags got %h want 1", flags); end
    tests++; if (start_trig !== 1'b1) begin fails++; $display("FAIL rise_start_trig got %b want 1", start_trig); end
    $display("[TB] test_trigger_rise done");
  endtask

  task automatic test_glitch();
    gpio[5] = 1'b1;
    tick(3);
    gpio[5] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      tests++;
      if ({stable[5], rise[5], fall[5], flags[5]} !== 4'b0000) begin
        fails++;
        $display("FAIL glitch_bit5 cycle %0d got %b want 0000", i, {stable[5], rise[5], fall[5], flags[5]});
      end
    end
    $display("[TB] test_glitch done");
  endtask

  task automatic test_bit44();
    int nr;
    int nf;
    nr = 0; nf = 0;
    gpio[44] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) gpio[44] = 1'b0;
      tick(1);
      nr += int'(rise[44]);
      nf += int'(fall[44]);
      tests++;
      if (rise[44] && fall[44]) begin fails++; $display("FAIL b44_both cycle %0d got rise&fall want exclusive", i); end
    end
    tests++; if (nr != 1) begin fails++; $display("FAIL b44_rises got %0d want 1", nr); end
    tests++; if (nf != 1) begin fails++; $display("FAIL b44_falls got %0d want 1", nf); end
    tests++; if (flags[44] !== 1'b1) begin fails++; $display("FAIL b44_flag got %b want 1", flags[44]); end
    tests++; if (stable[44] !== 1'b0) begin fails++; $display("FAIL b44_stable got %b want 0", stable[44]); end
    tests++; if (trig_cnt !== 4'd1) begin fails++; $display("FAIL b44_cnt got %0d want 1", trig_cnt); end
    $display("[TB] test_bit44 done");
  endtask

  task automatic test_clear_collision();
    for (int i = 0; i < 6; i++) begin
      gpio[0] = 1'b0; tick(8);
      gpio[0] = 1'b1; tick(8);
    end
    gpio[0] = 1'b0; tick(8);
    tests++; if (trig_cnt !== 4'd7) begin fails++; $display("FAIL clr_pre_cnt got %0d want 7", trig_cnt); end
    gpio[0] = 1'b1; tick(6);
    tests++; if (trig_pulse !== 1'b1) begin fails++; $display("FAIL clr_pulse_present got %b want 1", trig_pulse); end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tests++; if (trig_cnt !== 4'd1) begin fails++; $display("FAIL clr_cnt got %0d want 1", trig_cnt); end
    tests++; if (flags !== 45'h1) begin fails++; $display("FAIL clr_flags got %h want 1", flags); end
    $display("[TB] test_clear_collision done");
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 17; i++) begin
      gpio[0] = 1'b0; tick(8);
      gpio[0] = 1'b1; tick(8);
      if (i == 13) begin
        tests++; if (trig_cnt !== 4'd14) begin fails++; $display("FAIL sat_mid got %0d want 14", trig_cnt); end
      end
    end
    tests++; if (trig_cnt !== 4'd15) begin fails++; $display("FAIL sat_final got %0d want 15", trig_cnt); end
    $display("[TB] test_saturation done");
  endtask

  task automatic test_reset_mid_debounce();
    gpio = '0; tick(8);
    gpio = '1;
    tick(4);                 // two counter increments recorded
    rst = 1'b1; clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      tests++;
      if ((stable | rise | fall | flags) !== '0 || trig_cnt !== '0 || start_trig !== 1'b0 || trig_pulse !== 1'b0) begin
        fails++;
        $display("FAIL rst_hold cycle %0d got st=%h r=%h f=%h fl=%h c=%0d want all 0", i, stable, rise, fall, flags, trig_cnt);
      end
    end
    rst = 1'b0; clr = 1'b0;
    tick(1 + DC);            // edge 1+DC after deassert
    tests++; if ((stable | rise) !== '0) begin fails++; $display("FAIL rst_early got st=%h r=%h want 0", stable, rise); end
    tick(1);                 // edge 2+DC
    tests++; if (rise !== '1) begin fails++; $display("FAIL rst_rise_all got %h want all ones", rise); end
    tests++; if (fall !== '0) begin fails++; $display("FAIL rst_no_fall got %h want 0", fall); end
    tests++; if (trig_pulse !== 1'b1) begin fails++; $display("FAIL rst_trig_pulse got %b want 1", trig_pulse); end
    tick(1);
    tests++; if (flags !== '1) begin fails++; $display("FAIL rst_flags got %h want all ones", flags); end
    tests++; if (trig_cnt !== 4'd1) begin fails++; $display("FAIL rst_cnt got %0d want 1", trig_cnt); end
    $display("[TB] test_reset_mid_debounce done");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_trigger_rise();
    test_glitch();
    test_bit44();
    test_clear_collision();
    test_saturation();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gpio_input_monitor.md
Name: gpio_input_monitor

Overview:
- Receive-side counterpart of the board GPIO output driver.
- Samples a 45-bit bank of 1.8 V GPIO inputs and synchronises it into sys_clk_i with two flops.
- Debounces each bit independently, then produces stable levels, single-cycle rise/fall pulses, sticky change flags and a start-trigger level/pulse taken from one selected bit.
- Sits between the board GPIO pads and the control logic that consumes external start triggers.

Parameters:
- WIDTH, 45, number of GPIO input bits.
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised bit must differ from its stable value before the stable value flips; legal range 1..255.
- TRIG_BIT, 0, index of the bit that drives start_trigger_o and trig_pulse_o; legal range 0..WIDTH-1.
- CNT_W, 16, width of the trigger event counter.

Ports:
- sys_clk_i  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  synchronous reset, active high.
- gpio_i  input  WIDTH  raw asynchronous GPIO inputs.
- clear_i  input  1  single-cycle pulse; clears change_flags_o and trig_cnt_o.
- gpio_stable_o  output  WIDTH  debounced level per bit.
- rise_o  output  WIDTH  one-cycle pulse per bit when its stable level goes 0->1.
- fall_o  output  WIDTH  one-cycle pulse per bit when its stable level goes 1->0.
- change_flags_o  output  WIDTH  sticky per-bit flag; set on any stable edge.
- start_trigger_o  output  1  equals gpio_stable_o[TRIG_BIT].
- trig_pulse_o  output  1  equals rise_o[TRIG_BIT].
- trig_cnt_o  output  CNT_W  saturating count of rising edges on TRIG_BIT.

Behaviour:
- Interface: one clock (sys_clk_i); reset rst_i is synchronous and active-high.
- Reset (rst_i high at an edge):
  - Both sync stages, all debounce counters, gpio_stable_o, rise_o, fall_o, change_flags_o and trig_cnt_o go to 0.
  - start_trigger_o and trig_pulse_o therefore read 0.
  - Reset has priority over every other event, including clear_i.
- Synchroniser: sync1 <= gpio_i; sync2 <= sync1. No other logic reads gpio_i directly.
- Debounce, per bit, each edge:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0, and rise or fall <= 1 for exactly one cycle.
  - Otherwise counter <= counter+1.
  - Counter width is 8 bits.
- Latency: a clean pin change captured into sync1 at edge k makes the stable level flip at edge k+1+DEBOUNCE_CYCLES. The edge pulse is registered at that same edge.
- Glitch rejection: a disagreement lasting fewer than DEBOUNCE_CYCLES consecutive sync2 samples resets the counter and produces no edge.
- DEBOUNCE_CYCLES=1: the stable level follows sync2 with one edge of delay, and every sync2 change produces a pulse.
- rise_o and fall_o:
  - Both are 0 in every cycle without a flip.
  - They are never high together on the same bit.
  - Pulses on different bits are fully independent.
- change_flags_o:
  - Bit set when rise or fall is asserted for that bit.
  - All bits cleared by clear_i.
  - If a set and clear_i occur in the same cycle, the set wins and the bit ends at 1.
- trig_cnt_o:
  - Increments on each trig_pulse_o and saturates at 2^CNT_W-1 (no wrap).
  - clear_i zeroes it.
  - If clear_i and a pulse occur in the same cycle, the result is 1.
- start_trigger_o and trig_pulse_o are direct copies of the registered stable and rise bits, with no extra delay.
- Reset mid-debounce: the partial count is discarded. A pin held high through reset produces a rise 2+DEBOUNCE_CYCLES edges after rst_i deasserts.

Test Plan:
- Reset release with gpio_i=0, then drive gpio_i[0]=1 (DEBOUNCE_CYCLES=4) -> gpio_stable_o[0] rises exactly 5 edges after sync1 captures it; rise_o[0] and trig_pulse_o high for 1 cycle; trig_cnt_o=1; change_flags_o=0x1.
- Glitch on gpio_i[5] lasting 3 cycles (DEBOUNCE_CYCLES=4) -> no change on gpio_stable_o, rise_o, fall_o or change_flags_o.
- Drive gpio_i[44] 0->1->0, each level held 10 cycles -> one rise_o[44] pulse, one fall_o[44] pulse, change_flags_o[44]=1; trig_cnt_o unchanged.
- clear_i asserted in the same cycle as a TRIG_BIT rise with trig_cnt_o=7 and change_flags_o[0]=1 -> trig_cnt_o=1, change_flags_o[0]=1, all other flags 0.
- Preload toward saturation with CNT_W=4 and apply 17 TRIG_BIT rises -> trig_cnt_o stops at 15.
- Toggle all 45 bits simultaneously, then assert rst_i after 2 counter cycles with pins held -> all outputs 0 during reset; all 45 rise pulses appear together exactly 2+DEBOUNCE_CYCLES edges after deassert.
